uart_rx: RTL and testbench
==========================

# uart_rx

UART receive stage: the downstream consumer of the UART transmitter's serial line in the multi-clock system. Oversamples `RX_IN` at a configurable prescale, detects the start bit, recovers 8 data bits LSB-first with 3-sample majority voting, optionally checks parity, validates the stop bit, and presents the byte with a one-cycle valid pulse. Frame format matches the transmitter: start(0), 8 data bits, optional parity, stop(1).

## Interface
- `DATA_WIDTH`, 8, data bits per frame.
- `PRESCALE_WIDTH`, 6, width of the `PRESCALE` input.
- `CLK`  in  1  receiver oversampling clock.
- `RST`  in  1  reset; synchronous, active-high.
- `RX_IN`  in  1  serial line, idle high, already synchronised to `CLK`.
- `PRESCALE`  in  PRESCALE_WIDTH  oversampling ratio; legal values 8, 16, 32.
- `PAR_EN`  in  1  1 = parity bit present.
- `PAR_TYP`  in  1  0 = even parity, 1 = odd parity.
- `P_DATA`  out  DATA_WIDTH  last correctly received byte.
- `data_valid`  out  1  one-cycle pulse, `P_DATA` newly updated.
- `par_err`  out  1  one-cycle pulse, parity mismatch in completed frame.
- `stp_err`  out  1  one-cycle pulse, stop bit sampled 0.
- `busy`  out  1  high while a frame is in progress (state ≠ IDLE).

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: `RX_IN`=0 → START; clear edge counter and bit counter; latch `PRESCALE`, `PAR_EN`, `PAR_TYP` for the frame. Mid-frame changes to these inputs are ignored.
- Edge counter counts 0..P-1 per bit (P = latched prescale). Illegal `PRESCALE` values behave as 8.
- Samples are taken at edge counts P/2-1, P/2, P/2+1. The bit value is the majority of the three, decided at P/2+1.
- START: decided bit = 1 → glitch; return to IDLE at the decision cycle with no outputs. Decided bit = 0 → at edge P-1, go to DATA.
- DATA: shift decided bits into the shift register LSB-first. After bit 7 reaches edge P-1: go to PARITY if `PAR_EN`, else STOP.
- PARITY: compare the decided bit with the XOR of the data bits (inverted when `PAR_TYP`=1). Store the mismatch flag. Always proceed to STOP; a parity error does not abort the frame.
- STOP: decided bit = 0 → stop-error flag. At edge P-1 the frame ends:
  - No errors: `P_DATA` ← shift register, `data_valid` pulses.
  - Any error: `P_DATA` holds its previous value. `par_err`/`stp_err` pulse as applicable; both may pulse together.
- After frame end: `RX_IN`=0 at the end cycle → go directly to START (back-to-back frames, no idle cycle needed). Otherwise → IDLE.
- Reset: state IDLE, counters 0, shift register 0. All outputs are 0 (`P_DATA`=0). Reset mid-frame discards the partial frame with no pulses.

## Timing
- All outputs are registered; output pulses are exactly one `CLK` cycle wide.
- Start detect: the cycle after `RX_IN` is sampled low, state = START and edge count = 0.
- Frame length from start detect to output pulse: (10 + `PAR_EN`) × P cycles. Pulses appear in the cycle after STOP edge P-1.
- `busy` rises the cycle after start detect. It falls the cycle after frame end, unless a back-to-back start keeps it high.
- `P_DATA` stays stable from a `data_valid` pulse until the next one.

## Structure
- Shared package `uart_rx_pkg`:
  - state enum;
  - legal prescale constants 8/16/32;
  - parity-type encodings (PAR_EVEN=0, PAR_ODD=1).
- Sub-module `uart_rx_sampler`:
  - edge counter and bit counter;
  - 3-sample majority vote;
  - outputs `sampled_bit`, `bit_decided` (strobe at P/2+1) and `bit_end` (strobe at P-1).
- The top holds the FSM, shift register, parity check and output registers.

## Test plan
- P=8, no parity, byte 0xA5 → `data_valid` pulse after 80 cycles; `P_DATA`=0xA5; no error pulses.
- P=16, even parity, byte 0x3C sent with parity bit 1 → `par_err` pulse; no `data_valid`; `P_DATA` unchanged.
- P=32, odd parity, byte 0x01 with parity 0, stop bit forced 0 → `stp_err` pulse only; next good frame 0x7E is received correctly.
- Start glitch: `RX_IN` low for 2 cycles at P=16 → return to IDLE; `busy` falls; no pulses.
- Back-to-back frames 0x55, 0xAA at P=8 with no idle gap → two `data_valid` pulses exactly 80 cycles apart with correct bytes.
- One sample inverted per bit (at P/2-1) on frame 0xC3 → majority vote recovers 0xC3. `RST` asserted mid-DATA → outputs 0 and state IDLE next cycle.

Source files
------------

// File: rtl/uart_rx_pkg.sv
//==============================================================================
// Module      : uart_rx_pkg
// Description : Shared types and constants for the UART receive stage.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package uart_rx_pkg;

  // Receiver frame states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  // Oversampling ratios the receiver accepts
  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

  // Parity type encodings
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // True when the requested oversampling ratio is one the receiver supports
  function automatic logic is_legal_prescale(input int p);
    return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_if.sv
//==============================================================================
// Module      : uart_rx_if
// Description : Serial line, frame configuration and received-byte outputs of
//               the UART receive stage.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface uart_rx_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
);

  logic                      RX_IN;
  logic [PRESCALE_WIDTH-1:0] PRESCALE;
  logic                      PAR_EN;
  logic                      PAR_TYP;
  logic [DATA_WIDTH-1:0]     P_DATA;
  logic                      data_valid;
  logic                      par_err;
  logic                      stp_err;
  logic                      busy;

  // Line driver / byte consumer side
  modport master (
    output RX_IN, PRESCALE, PAR_EN, PAR_TYP,
    input  P_DATA, data_valid, par_err, stp_err, busy
  );

  // Receiver side
  modport slave (
    input  RX_IN, PRESCALE, PAR_EN, PAR_TYP,
    output P_DATA, data_valid, par_err, stp_err, busy
  );

endinterface

`default_nettype wire

// File: rtl/uart_rx_sampler.sv
//==============================================================================
// Module      : uart_rx_sampler
// Description : Per-bit edge counter, bit counter and 3-sample majority vote.
//               Samples at P/2-1 and P/2 are stored; the live line value at
//               P/2+1 completes the vote, so the decision is available in that
//               same cycle.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_rx_sampler #(
  parameter int PRESCALE_WIDTH = 6,
  parameter int BIT_CNT_WIDTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx_in,
  input  logic                      clear,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      sampled_bit,
  output logic                      bit_decided,
  output logic                      bit_end,
  output logic [BIT_CNT_WIDTH-1:0]  bit_cnt
);

  logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
  logic [BIT_CNT_WIDTH-1:0]  bit_cnt_q, bit_cnt_d;
  logic                      s0_q, s0_d;
  logic                      s1_q, s1_d;
  logic [PRESCALE_WIDTH-1:0] half;

  assign half        = prescale >> 1;
  assign bit_decided = (edge_cnt_q == half + PRESCALE_WIDTH'(1));
  assign bit_end     = (edge_cnt_q == prescale - PRESCALE_WIDTH'(1));
  assign sampled_bit = (s0_q & s1_q) | (s0_q & rx_in) | (s1_q & rx_in);
  assign bit_cnt     = bit_cnt_q;

  // Advance the edge/bit counters and capture the first two votes
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    s0_d       = s0_q;
    s1_d       = s1_q;

    if (clear) begin
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (bit_end) begin
      edge_cnt_d = '0;
      bit_cnt_d  = bit_cnt_q + BIT_CNT_WIDTH'(1);
    end else begin
      edge_cnt_d = edge_cnt_q + PRESCALE_WIDTH'(1);
    end

    if (edge_cnt_q == half - PRESCALE_WIDTH'(1)) s0_d = rx_in;
    if (edge_cnt_q == half)                      s1_d = rx_in;
  end

  // Counter and vote registers
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      s0_q       <= 1'b1;
      s1_q       <= 1'b1;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
//==============================================================================
// Module      : uart_rx
// Description : UART receive stage. Start detect, LSB-first data recovery,
//               optional parity check and stop-bit validation with registered
//               one-cycle result pulses.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic     CLK,
  input  logic     RST,
  uart_rx_if.slave bus
);

  // Bit counter spans start, data, parity and stop periods
  localparam int BIT_CNT_WIDTH = $clog2(DATA_WIDTH + 3);

  state_e                    state_q, state_d;
  logic [DATA_WIDTH-1:0]     shift_q, shift_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic                      par_en_q, par_en_d;
  logic                      par_typ_q, par_typ_d;
  logic                      par_flag_q, par_flag_d;
  logic                      stp_flag_q, stp_flag_d;
  logic [DATA_WIDTH-1:0]     p_data_q, p_data_d;
  logic                      data_valid_q, data_valid_d;
  logic                      par_err_q, par_err_d;
  logic                      stp_err_q, stp_err_d;
  logic                      busy_q, busy_d;

  logic                      start_frame;
  logic                      frame_end;
  logic                      sampler_clear;
  logic                      sampled_bit;
  logic                      bit_decided;
  logic                      bit_end;
  logic [BIT_CNT_WIDTH-1:0]  bit_cnt;

  // Counters sit at zero while idle and restart on every frame boundary so a
  // back-to-back start bit is timed from edge 0.
  assign sampler_clear = (state_q == ST_IDLE) || frame_end;

  uart_rx_sampler #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH),
    .BIT_CNT_WIDTH  (BIT_CNT_WIDTH)
  ) u_sampler (
    .clk         (CLK),
    .rst         (RST),
    .rx_in       (bus.RX_IN),
    .clear       (sampler_clear),
    .prescale    (prescale_q),
    .sampled_bit (sampled_bit),
    .bit_decided (bit_decided),
    .bit_end     (bit_end),
    .bit_cnt     (bit_cnt)
  );

  // Next-state, datapath and output-pulse logic
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    prescale_d   = prescale_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    par_flag_d   = par_flag_q;
    stp_flag_d   = stp_flag_q;
    p_data_d     = p_data_q;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stp_err_d    = 1'b0;
    busy_d       = (state_q != ST_IDLE);
    start_frame  = 1'b0;
    frame_end    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!bus.RX_IN) begin
          start_frame = 1'b1;
          state_d     = ST_START;
        end
      end

      ST_START: begin
        // A start bit that votes high was a glitch: abandon silently
        if (bit_decided && sampled_bit) begin
          state_d = ST_IDLE;
        end else if (bit_end) begin
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        if (bit_decided) begin
          shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
        end
        if (bit_end && (bit_cnt == BIT_CNT_WIDTH'(DATA_WIDTH))) begin
          state_d = par_en_q ? ST_PARITY : ST_STOP;
        end
      end

      ST_PARITY: begin
        if (bit_decided) begin
          par_flag_d = sampled_bit != ((^shift_q) ^ (par_typ_q == PAR_ODD));
        end
        if (bit_end) begin
          state_d = ST_STOP;
        end
      end

      ST_STOP: begin
        if (bit_decided && !sampled_bit) begin
          stp_flag_d = 1'b1;
        end
        if (bit_end) begin
          frame_end = 1'b1;
          if (!par_flag_q && !stp_flag_q) begin
            p_data_d     = shift_q;
            data_valid_d = 1'b1;
          end
          par_err_d = par_flag_q;
          stp_err_d = stp_flag_q;
          if (!bus.RX_IN) begin
            start_frame = 1'b1;
            state_d     = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Frame configuration is frozen at each start detect
    if (start_frame) begin
      prescale_d = is_legal_prescale(int'(bus.PRESCALE)) ?
                   bus.PRESCALE : PRESCALE_WIDTH'(PRESCALE_8);
      par_en_d   = bus.PAR_EN;
      par_typ_d  = bus.PAR_TYP;
      par_flag_d = 1'b0;
      stp_flag_d = 1'b0;
    end
  end

  // State, datapath and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      prescale_q   <= PRESCALE_WIDTH'(PRESCALE_8);
      par_en_q     <= 1'b0;
      par_typ_q    <= PAR_EVEN;
      par_flag_q   <= 1'b0;
      stp_flag_q   <= 1'b0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      prescale_q   <= prescale_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      par_flag_q   <= par_flag_d;
      stp_flag_q   <= stp_flag_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.P_DATA     = p_data_q;
  assign bus.data_valid = data_valid_q;
  assign bus.par_err    = par_err_q;
  assign bus.stp_err    = stp_err_q;
  assign bus.busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
//==============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx: table of single frames plus
//               glitch, back-to-back and mid-frame reset sequences.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_uart_rx;
  import uart_rx_pkg::*;

  typedef struct {
    int         p;         // line bit period in cycles
    logic [5:0] pin;       // value driven on PRESCALE
    logic       par_en;
    logic       par_typ;
    logic [7:0] data;
    logic       par_bit;
    logic       stop_bit;
    logic       inv;       // invert the line at the first vote sample of every bit
    logic       exp_dv;
    logic       exp_pe;
    logic       exp_se;
    logic [7:0] exp_pdata;
  } vec_t;

  localparam int NV = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_rx_if #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) bus ();

  uart_rx #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   n_pe    = 0;
  int   n_se    = 0;
  int   dv_cyc[$];
  logic [7:0] dv_data[$];
  vec_t vecs[NV];

  // Pulse log
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.data_valid === 1'b1) begin
      dv_cyc.push_back(cyc);
      dv_data.push_back(bus.P_DATA);
    end
    if (bus.par_err === 1'b1) n_pe <= n_pe + 1;
    if (bus.stp_err === 1'b1) n_se <= n_se + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int p, input logic [5:0] pin, input logic pen,
                              input logic ptyp, input logic [7:0] d, input logic pbit,
                              input logic sbit, input logic inv, input logic edv,
                              input logic epe, input logic ese, input logic [7:0] epd);
    vec_t v;
    v.p = p; v.pin = pin; v.par_en = pen; v.par_typ = ptyp; v.data = d;
    v.par_bit = pbit; v.stop_bit = sbit; v.inv = inv; v.exp_dv = edv;
    v.exp_pe = epe; v.exp_se = ese; v.exp_pdata = epd;
    return v;
  endfunction

  // Drive one frame, one line value per negedge. Config inputs are set on the
  // start-bit cycle and scrambled right after, so only the latched copy counts.
  task automatic send_frame(input int p, input logic [5:0] pin, input logic pen,
                            input logic ptyp, input logic [7:0] data, input logic pbit,
                            input logic sbit, input logic inv, input int max_cycles);
    logic [10:0] bits;
    int nb;
    int idx;
    bits = '1;
    bits[0] = 1'b0;
    for (int b = 0; b < 8; b++) bits[b+1] = data[b];
    nb = 9;
    if (pen) begin
      bits[nb] = pbit;
      nb++;
    end
    bits[nb] = sbit;
    nb++;
    idx = 0;
    for (int b = 0; b < nb; b++) begin
      for (int j = 0; j < p; j++) begin
        if (max_cycles > 0 && idx >= max_cycles) return;
        @(negedge clk);
        if (idx == 0) begin
          bus.PRESCALE = pin;
          bus.PAR_EN   = pen;
          bus.PAR_TYP  = ptyp;
        end else if (idx == 1) begin
          bus.PRESCALE = (pin == 6'd16) ? 6'd32 : 6'd16;
          bus.PAR_EN   = ~pen;
          bus.PAR_TYP  = ~ptyp;
        end
        bus.RX_IN = bits[b] ^ (inv && (j == p / 2));
        idx++;
      end
    end
  endtask

  initial begin
    int pe0, se0, busy_mid;

    vecs[0] = mk( 8, 6'd8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5);
    vecs[1] = mk(16, 6'd16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5);
    vecs[2] = mk(32, 6'd32, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5);
    vecs[3] = mk(32, 6'd32, 1'b1, 1'b1, 8'h7E, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h7E);
    vecs[4] = mk( 8, 6'd8,  1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hC3);
    vecs[5] = mk(16, 6'd16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C);
    vecs[6] = mk( 8, 6'd8,  1'b1, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C);
    vecs[7] = mk( 8, 6'd12, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A);
    vecs[8] = mk(32, 6'd32, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF);
    vecs[9] = mk(16, 6'd16, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);

    bus.RX_IN    = 1'b1;
    bus.PRESCALE = 6'd8;
    bus.PAR_EN   = 1'b0;
    bus.PAR_TYP  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst P_DATA",     32'(bus.P_DATA),     32'h0);
    check("rst data_valid", 32'(bus.data_valid), 32'h0);
    check("rst par_err",    32'(bus.par_err),    32'h0);
    check("rst stp_err",    32'(bus.stp_err),    32'h0);
    check("rst busy",       32'(bus.busy),       32'h0);
    check("rst state",      32'(dut.state_q == ST_IDLE), 32'h1);
    rst = 1'b0;

    // Single frames: result pulses exactly (10 + PAR_EN) * P cycles after start detect
    for (int i = 0; i < NV; i++) begin
      repeat (3) @(negedge clk);
      dv_cyc.delete();
      dv_data.delete();
      send_frame(vecs[i].p, vecs[i].pin, vecs[i].par_en, vecs[i].par_typ, vecs[i].data,
                 vecs[i].par_bit, vecs[i].stop_bit, vecs[i].inv, 0);
      @(negedge clk);
      bus.RX_IN = 1'b1;
      @(negedge clk);
      check($sformatf("v%0d data_valid", i), 32'(bus.data_valid), 32'(vecs[i].exp_dv));
      check($sformatf("v%0d par_err", i),    32'(bus.par_err),    32'(vecs[i].exp_pe));
      check($sformatf("v%0d stp_err", i),    32'(bus.stp_err),    32'(vecs[i].exp_se));
      check($sformatf("v%0d P_DATA", i),     32'(bus.P_DATA),     32'(vecs[i].exp_pdata));
      @(negedge clk);
      check($sformatf("v%0d pulse width", i),
            32'({bus.data_valid, bus.par_err, bus.stp_err}), 32'h0);
      check($sformatf("v%0d dv count", i), 32'(dv_cyc.size()), 32'(vecs[i].exp_dv));
    end

    // Start glitch: two low cycles at P=16
    repeat (3) @(negedge clk);
    dv_cyc.delete();
    dv_data.delete();
    pe0 = n_pe;
    se0 = n_se;
    bus.PRESCALE = 6'd16;
    bus.RX_IN = 1'b0;
    @(negedge clk);
    bus.RX_IN = 1'b0;
    @(negedge clk);
    bus.RX_IN = 1'b1;
    repeat (4) @(negedge clk);
    busy_mid = int'(bus.busy);
    repeat (40) @(negedge clk);
    check("glitch busy mid",  32'(busy_mid), 32'h1);
    check("glitch busy end",  32'(bus.busy), 32'h0);
    check("glitch state",     32'(dut.state_q == ST_IDLE), 32'h1);
    check("glitch dv count",  32'(dv_cyc.size()), 32'h0);
    check("glitch err count", 32'((n_pe - pe0) + (n_se - se0)), 32'h0);

    // Back-to-back frames at P=8
    dv_cyc.delete();
    dv_data.delete();
    send_frame(8, 6'd8, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0, 0);
    send_frame(8, 6'd8, 1'b0, 1'b0, 8'hAA, 1'b0, 1'b1, 1'b0, 0);
    @(negedge clk);
    bus.RX_IN = 1'b1;
    repeat (5) @(negedge clk);
    check("b2b dv count", 32'(dv_cyc.size()), 32'h2);
    if (dv_cyc.size() == 2) begin
      check("b2b byte0",   32'(dv_data[0]), 32'h55);
      check("b2b byte1",   32'(dv_data[1]), 32'hAA);
      check("b2b spacing", 32'(dv_cyc[1] - dv_cyc[0]), 32'd80);
    end

    // Reset in the middle of the data bits
    repeat (3) @(negedge clk);
    send_frame(8, 6'd8, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b0, 30);
    @(negedge clk);
    rst = 1'b1;
    bus.RX_IN = 1'b1;
    @(negedge clk);
    check("midrst P_DATA",     32'(bus.P_DATA), 32'h0);
    check("midrst busy",       32'(bus.busy),   32'h0);
    check("midrst state",      32'(dut.state_q == ST_IDLE), 32'h1);
    check("midrst data_valid", 32'(bus.data_valid), 32'h0);
    rst = 1'b0;
    dv_cyc.delete();
    dv_data.delete();
    pe0 = n_pe;
    se0 = n_se;
    repeat (100) @(negedge clk);
    check("midrst no pulses", 32'(dv_cyc.size() + (n_pe - pe0) + (n_se - se0)), 32'h0);

    // Recovery after reset: a majority-vote frame is received normally
    send_frame(8, 6'd8, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b1, 0);
    @(negedge clk);
    bus.RX_IN = 1'b1;
    @(negedge clk);
    check("recover data_valid", 32'(bus.data_valid), 32'h1);
    check("recover P_DATA",     32'(bus.P_DATA),     32'hC3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
